// File: rtl/conv3x3_rgb565_prog_pkg.sv
// Shared constants and helpers for the programmable 3x3 RGB565 convolution engine.
// Holds the field layout, channel limits, default kernel and window slicing.
package conv3x3_rgb565_prog_pkg;

    localparam int N_TAPS = 9;
    localparam int PIX_W  = 16;
    localparam int CENTRE = 4;

    localparam int R_OFF = 11;
    localparam int G_OFF = 5;
    localparam int B_OFF = 0;
    localparam int R_W   = 5;
    localparam int G_W   = 6;
    localparam int B_W   = 5;

    localparam int R_MAX = 31;
    localparam int G_MAX = 63;
    localparam int B_MAX = 31;

    // Gaussian 1-2-1 kernel, row-major from the top-left tap.
    function automatic int def_coef(input int i);
        case (i)
            0, 2, 6, 8: return 1;
            4:          return 4;
            default:    return 2;
        endcase
    endfunction

    function automatic logic [PIX_W-1:0] pixel_at(input logic [N_TAPS*PIX_W-1:0] win, input int i);
        return win[N_TAPS*PIX_W-1-PIX_W*i -: PIX_W];
    endfunction

endpackage

// File: rtl/conv3x3_mac_channel.sv
// One colour channel of the convolution: 9 signed products, a sum stage,
// then combinational round, arithmetic shift and clamp to the channel range.
module conv3x3_mac_channel
    import conv3x3_rgb565_prog_pkg::*;
#(
    parameter int CH_W   = 5,
    parameter int COEF_W = 8
) (
    input  logic                     d_clk,
    input  logic [CH_W-1:0]          ch   [N_TAPS],
    input  logic signed [COEF_W-1:0] coef [N_TAPS],
    input  logic [3:0]               shift,
    output logic [CH_W-1:0]          result
);

    localparam int PW = COEF_W + 7;
    localparam int SW = COEF_W + 11;
    // Extra headroom so the rounding constant can never overflow the sum.
    localparam int RW = SW + 16;
    localparam logic signed [RW-1:0] CH_MAX = RW'((1 << CH_W) - 1);

    logic signed [PW-1:0] prod_q [N_TAPS];
    logic signed [SW-1:0] sum_d;
    logic signed [SW-1:0] sum_q;
    logic signed [RW-1:0] rnd;
    logic signed [RW-1:0] shifted;

    // NOTE: datapath registers carry no reset; their contents are ignored
    // whenever the matching valid bit (held in the parent) is low.
    always_ff @(posedge d_clk) begin
        for (int i = 0; i < N_TAPS; i++) begin
            prod_q[i] <= PW'(coef[i]) * $signed(PW'({1'b0, ch[i]}));
        end
        sum_q <= sum_d;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < N_TAPS; i++) begin
            sum_d = sum_d + SW'(prod_q[i]);
        end
    end

    always_comb begin
        rnd = RW'(sum_q);
        if (shift != 4'd0) begin
            rnd = rnd + (RW'(1) <<< (shift - 4'd1));
        end
        shifted = rnd >>> shift;
        if (shifted[RW-1]) begin
            result = '0;
        end else if (shifted > CH_MAX) begin
            result = CH_MAX[CH_W-1:0];
        end else begin
            result = shifted[CH_W-1:0];
        end
    end

endmodule

// File: rtl/conv3x3_rgb565_prog.sv
// Programmable 3x3 RGB565 convolution with shadow/active config swapped at vsync,
// a centre-pixel bypass path and frame-buffer write addressing. Latency is 3.
module conv3x3_rgb565_prog
    import conv3x3_rgb565_prog_pkg::*;
#(
    parameter int COEF_W       = 8,
    parameter int DEF_SHIFT    = 4,
    parameter int FRAME_PIXELS = 76800,
    parameter int ADDR_W       = 18
) (
    input  logic                     d_clk,
    input  logic                     rst_n,
    input  logic                     valid_in,
    input  logic                     vsync,
    input  logic [143:0]             RGB_data,
    input  logic                     coef_we,
    input  logic [3:0]               coef_idx,
    input  logic signed [COEF_W-1:0] coef_data,
    input  logic                     shift_we,
    input  logic [3:0]               shift_data,
    input  logic                     bypass_we,
    input  logic                     bypass_data,
    input  logic                     cfg_commit,
    output logic                     cfg_pending,
    output logic                     valid_out,
    output logic [15:0]              convolved_rgb,
    output logic [ADDR_W-1:0]        bram_addr,
    output logic                     frame_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

    logic signed [COEF_W-1:0] shadow_coef [N_TAPS];
    logic signed [COEF_W-1:0] active_coef [N_TAPS];
    logic [3:0]               shadow_shift, active_shift;
    logic                     shadow_bypass, active_bypass;
    logic                     swap;

    assign swap = cfg_pending & vsync;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge d_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_TAPS; i++) begin
                shadow_coef[i] <= COEF_W'(def_coef(i));
                active_coef[i] <= COEF_W'(def_coef(i));
            end
            shadow_shift  <= 4'(DEF_SHIFT);
            active_shift  <= 4'(DEF_SHIFT);
            shadow_bypass <= 1'b0;
            active_bypass <= 1'b0;
            cfg_pending   <= 1'b0;
        end else begin
            if (coef_we && (coef_idx < 4'(N_TAPS))) begin
                shadow_coef[coef_idx] <= coef_data;
            end
            if (shift_we) begin
                shadow_shift <= shift_data;
            end
            if (bypass_we) begin
                shadow_bypass <= bypass_data;
            end
            if (swap) begin
                active_coef   <= shadow_coef;
                active_shift  <= shadow_shift;
                active_bypass <= shadow_bypass;
            end
            // A commit landing on the swap cycle re-arms for the next frame.
            if (cfg_commit) begin
                cfg_pending <= 1'b1;
            end else if (swap) begin
                cfg_pending <= 1'b0;
            end
        end
    end

    logic [PIX_W-1:0] px    [N_TAPS];
    logic [R_W-1:0]   r_win [N_TAPS];
    logic [G_W-1:0]   g_win [N_TAPS];
    logic [B_W-1:0]   b_win [N_TAPS];

    always_comb begin
        for (int i = 0; i < N_TAPS; i++) begin
            px[i]    = pixel_at(RGB_data, i);
            r_win[i] = px[i][R_OFF +: R_W];
            g_win[i] = px[i][G_OFF +: G_W];
            b_win[i] = px[i][B_OFF +: B_W];
        end
    end

    logic [R_W-1:0] r_res;
    logic [G_W-1:0] g_res;
    logic [B_W-1:0] b_res;
    logic [3:0]     shift_s1, shift_s2;

    conv3x3_mac_channel #(.CH_W(R_W), .COEF_W(COEF_W)) u_mac_r (
        .d_clk(d_clk), .ch(r_win), .coef(active_coef), .shift(shift_s2), .result(r_res)
    );
    conv3x3_mac_channel #(.CH_W(G_W), .COEF_W(COEF_W)) u_mac_g (
        .d_clk(d_clk), .ch(g_win), .coef(active_coef), .shift(shift_s2), .result(g_res)
    );
    conv3x3_mac_channel #(.CH_W(B_W), .COEF_W(COEF_W)) u_mac_b (
        .d_clk(d_clk), .ch(b_win), .coef(active_coef), .shift(shift_s2), .result(b_res)
    );

    // Shift and bypass travel with the pixel so each one uses the config of its S1 cycle.
    logic             v_s1, v_s2;
    logic             byp_s1, byp_s2;
    logic [PIX_W-1:0] centre_s1, centre_s2;

    always_ff @(posedge d_clk or negedge rst_n) begin
        if (!rst_n) begin
            v_s1          <= 1'b0;
            v_s2          <= 1'b0;
            byp_s1        <= 1'b0;
            byp_s2        <= 1'b0;
            shift_s1      <= '0;
            shift_s2      <= '0;
            centre_s1     <= '0;
            centre_s2     <= '0;
            valid_out     <= 1'b0;
            convolved_rgb <= '0;
        end else begin
            v_s1          <= valid_in;
            v_s2          <= v_s1;
            byp_s1        <= active_bypass;
            byp_s2        <= byp_s1;
            shift_s1      <= active_shift;
            shift_s2      <= shift_s1;
            centre_s1     <= px[CENTRE];
            centre_s2     <= centre_s1;
            valid_out     <= v_s2;
            convolved_rgb <= byp_s2 ? centre_s2 : {r_res, g_res, b_res};
        end
    end

    always_ff @(posedge d_clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_addr  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= valid_out && (bram_addr == LAST_ADDR);
            if (vsync) begin
                bram_addr <= '0;
            end else if (valid_out) begin
                bram_addr <= (bram_addr == LAST_ADDR) ? '0 : bram_addr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_rgb565_prog.sv
// Directed bench for conv3x3_rgb565_prog: table of default-kernel windows plus
// sequences for config commit timing, bypass streaming, address wrap and reset.
module tb_conv3x3_rgb565_prog;

    logic              d_clk = 1'b0;
    logic              rst_n;
    logic              valid_in;
    logic              vsync;
    logic [143:0]      RGB_data;
    logic              coef_we;
    logic [3:0]        coef_idx;
    logic signed [7:0] coef_data;
    logic              shift_we;
    logic [3:0]        shift_data;
    logic              bypass_we;
    logic              bypass_data;
    logic              cfg_commit;
    logic              cfg_pending;
    logic              valid_out;
    logic [15:0]       convolved_rgb;
    logic [2:0]        bram_addr;
    logic              frame_done;

    int checks   = 0;
    int failures = 0;

    always #5 d_clk = ~d_clk;

    conv3x3_rgb565_prog #(
        .COEF_W(8), .DEF_SHIFT(4), .FRAME_PIXELS(4), .ADDR_W(3)
    ) dut (
        .d_clk(d_clk), .rst_n(rst_n), .valid_in(valid_in), .vsync(vsync),
        .RGB_data(RGB_data), .coef_we(coef_we), .coef_idx(coef_idx),
        .coef_data(coef_data), .shift_we(shift_we), .shift_data(shift_data),
        .bypass_we(bypass_we), .bypass_data(bypass_data), .cfg_commit(cfg_commit),
        .cfg_pending(cfg_pending), .valid_out(valid_out),
        .convolved_rgb(convolved_rgb), .bram_addr(bram_addr), .frame_done(frame_done)
    );

    typedef struct {
        string        name;
        logic [143:0] win;
        logic [15:0]  exp;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [143:0] make_win(input logic [15:0] centre, input logic [15:0] neigh);
        logic [143:0] w;
        for (int i = 0; i < 9; i++) begin
            w[143-16*i -: 16] = (i == 4) ? centre : neigh;
        end
        return w;
    endfunction

    // Drives one window, then checks nothing appears early and the result lands at latency 3.
    task automatic apply_pixel(input string name, input logic [143:0] win, input logic [15:0] exp);
        @(negedge d_clk);
        RGB_data = win;
        valid_in = 1'b1;
        @(negedge d_clk);
        valid_in = 1'b0;
        @(negedge d_clk);
        check({name, "_early"}, 16'(valid_out), 16'd0);
        @(negedge d_clk);
        check({name, "_valid"}, 16'(valid_out), 16'd1);
        check({name, "_data"}, convolved_rgb, exp);
    endtask

    task automatic write_coef(input int idx, input logic signed [7:0] val);
        @(negedge d_clk);
        coef_we   = 1'b1;
        coef_idx  = 4'(idx);
        coef_data = val;
        @(negedge d_clk);
        coef_we = 1'b0;
    endtask

    task automatic pulse_commit();
        @(negedge d_clk);
        cfg_commit = 1'b1;
        @(negedge d_clk);
        cfg_commit = 1'b0;
    endtask

    task automatic pulse_vsync();
        @(negedge d_clk);
        vsync = 1'b1;
        @(negedge d_clk);
        vsync = 1'b0;
    endtask

    logic [15:0] centres [6];
    int          fd_cnt;
    int          vo_cnt;

    initial begin
        rst_n = 1'b0; valid_in = 1'b0; vsync = 1'b0; RGB_data = '0;
        coef_we = 1'b0; coef_idx = '0; coef_data = '0;
        shift_we = 1'b0; shift_data = '0; bypass_we = 1'b0; bypass_data = 1'b0;
        cfg_commit = 1'b0;

        // Default Gaussian, shift 4 with rounding.
        vecs[0] = '{"flat_mid",    make_win(16'h8410, 16'h8410), 16'h8410};
        vecs[1] = '{"flat_zero",   make_win(16'h0000, 16'h0000), 16'h0000};
        vecs[2] = '{"flat_max",    make_win(16'hFFFF, 16'hFFFF), 16'hFFFF};
        vecs[3] = '{"centre_only", make_win(16'hFFFF, 16'h0000), 16'h4208};
        vecs[4] = '{"ring_only",   make_win(16'h0000, 16'hFFFF), 16'hBDF7};
        vecs[5] = '{"round_up",    make_win(16'h1000, 16'h0000), 16'h0800};
        vecs[6] = '{"round_down",  make_win(16'h0800, 16'h0000), 16'h0000};
        vecs[7] = '{"flat_r1",     make_win(16'h0800, 16'h0800), 16'h0800};

        repeat (2) @(negedge d_clk);
        check("rst_valid_out", 16'(valid_out), 16'd0);
        check("rst_rgb", convolved_rgb, 16'd0);
        check("rst_addr", 16'(bram_addr), 16'd0);
        check("rst_frame_done", 16'(frame_done), 16'd0);
        check("rst_pending", 16'(cfg_pending), 16'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            apply_pixel(vecs[i].name, vecs[i].win, vecs[i].exp);
        end

        // Sharpen kernel staged mid-frame: must stay inactive until vsync.
        for (int i = 0; i < 9; i++) begin
            write_coef(i, (i == 4) ? 8'sd5 : ((i % 2 == 1) ? -8'sd1 : 8'sd0));
        end
        @(negedge d_clk);
        shift_we = 1'b1; shift_data = 4'd0;
        @(negedge d_clk);
        shift_we = 1'b0;
        pulse_commit();
        check("pending_set", 16'(cfg_pending), 16'd1);
        apply_pixel("pending_still_gauss", make_win(16'hFFFF, 16'h0000), 16'h4208);
        check("pending_held", 16'(cfg_pending), 16'd1);
        pulse_vsync();
        check("pending_cleared", 16'(cfg_pending), 16'd0);
        apply_pixel("sharp_clamp_hi", make_win(16'hFFFF, 16'h0000), 16'hFFFF);
        apply_pixel("sharp_clamp_lo", make_win(16'h0000, 16'hFFFF), 16'h0000);
        apply_pixel("sharp_flat", make_win(16'h8410, 16'h8410), 16'h8410);

        // Bypass committed while vsync is already high: swap lands one cycle later.
        @(negedge d_clk);
        bypass_we = 1'b1; bypass_data = 1'b1;
        @(negedge d_clk);
        bypass_we = 1'b0;
        vsync = 1'b1; cfg_commit = 1'b1;
        @(negedge d_clk);
        cfg_commit = 1'b0;
        check("vs_commit_pending", 16'(cfg_pending), 16'd1);
        @(negedge d_clk);
        vsync = 1'b0;
        check("vs_commit_applied", 16'(cfg_pending), 16'd0);

        // Back-to-back bypass stream doubles as the address wrap test (FRAME_PIXELS=4).
        centres[0] = 16'h1234; centres[1] = 16'hABCD; centres[2] = 16'h0001;
        centres[3] = 16'hF800; centres[4] = 16'h07E0; centres[5] = 16'h5555;
        fd_cnt = 0;
        for (int t = 0; t < 11; t++) begin
            @(negedge d_clk);
            if (frame_done) fd_cnt++;
            if (t >= 3 && t <= 8) begin
                check($sformatf("byp_valid_%0d", t - 3), 16'(valid_out), 16'd1);
                check($sformatf("byp_data_%0d", t - 3), convolved_rgb, centres[t-3]);
                check($sformatf("addr_%0d", t - 3), 16'(bram_addr), 16'((t - 3) % 4));
            end
            if (t < 6) begin
                valid_in = 1'b1;
                RGB_data = make_win(centres[t], ~centres[t]);
            end else begin
                valid_in = 1'b0;
            end
        end
        check("frame_done_once", 16'(fd_cnt), 16'd1);
        check("stream_drained", 16'(valid_out), 16'd0);

        // Reset in the middle of a burst.
        for (int t = 0; t < 4; t++) begin
            @(negedge d_clk);
            valid_in = 1'b1;
            RGB_data = make_win(16'h1111 * 16'(t + 1), 16'h0000);
        end
        @(negedge d_clk);
        check("burst_active", 16'(valid_out), 16'd1);
        valid_in = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_valid_out", 16'(valid_out), 16'd0);
        check("midrst_rgb", convolved_rgb, 16'd0);
        check("midrst_addr", 16'(bram_addr), 16'd0);
        check("midrst_frame_done", 16'(frame_done), 16'd0);
        repeat (2) @(negedge d_clk);
        rst_n = 1'b1;
        vo_cnt = 0;
        for (int t = 0; t < 6; t++) begin
            @(negedge d_clk);
            if (valid_out) vo_cnt++;
        end
        check("no_ghost_pixels", 16'(vo_cnt), 16'd0);
        apply_pixel("post_rst_gauss", make_win(16'hFFFF, 16'h0000), 16'h4208);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
